rv32_single_cycle_top: RTL and testbench

// - Single-cycle RV32I integer datapath with no bus interface. Each clock it executes one 32-bit instruction.
// - The instruction is applied directly on a port; the PC is exported for observation only and does not fetch.
// - Contains control decode, immediate generator, 32x32 register file, ALU, PC logic and a small internal data memory.
// - Internal datapath nodes are brought out as ports for bring-up and verification.

---
 rtl/rv32_single_cycle_top.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_rv32_single_cycle_top.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_single_cycle_top.sv
// Single-cycle RV32I integer datapath: decode, immediates, regfile, ALU, PC and a small data memory.
// Latency: one instruction retires per clk edge; no backpressure, the instruction port is consumed every cycle.
module rv32_single_cycle_top #(
    parameter int          DMEM_WORDS = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [5:0]  cuOP,
    output logic [31:0] aluIn,
    output logic [31:0] muxOut,
    output logic [31:0] immOut,
    output logic [31:0] aluOut,
    output logic        zero,
    output logic        negative,
    output logic [31:0] memload,
    output logic [31:0] writeData
);

    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    typedef enum logic [5:0] {
        OP_ILLEGAL = 6'd0,
        OP_ADD     = 6'd1,
        OP_SUB     = 6'd2,
        OP_SLL     = 6'd3,
        OP_SLT     = 6'd4,
        OP_SLTU    = 6'd5,
        OP_XOR     = 6'd6,
        OP_SRL     = 6'd7,
        OP_SRA     = 6'd8,
        OP_OR      = 6'd9,
        OP_AND     = 6'd10,
        OP_ADDI    = 6'd11,
        OP_SLTI    = 6'd12,
        OP_SLTIU   = 6'd13,
        OP_XORI    = 6'd14,
        OP_ORI     = 6'd15,
        OP_ANDI    = 6'd16,
        OP_SLLI    = 6'd17,
        OP_SRLI    = 6'd18,
        OP_SRAI    = 6'd19,
        OP_LW      = 6'd20,
        OP_SW      = 6'd21,
        OP_BEQ     = 6'd22,
        OP_BNE     = 6'd23,
        OP_BLT     = 6'd24,
        OP_BGE     = 6'd25,
        OP_BLTU    = 6'd26,
        OP_BGEU    = 6'd27,
        OP_JAL     = 6'd28,
        OP_JALR    = 6'd29,
        OP_LUI     = 6'd30,
        OP_AUIPC   = 6'd31
    } op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];

    op_e op;

    always_comb begin
        op = OP_ILLEGAL;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'd0: op = OP_ADD;
                        3'd1: op = OP_SLL;
                        3'd2: op = OP_SLT;
                        3'd3: op = OP_SLTU;
                        3'd4: op = OP_XOR;
                        3'd5: op = OP_SRL;
                        3'd6: op = OP_OR;
                        3'd7: op = OP_AND;
                        default: op = OP_ILLEGAL;
                    endcase
                end else if (funct7 == 7'h20) begin
                    case (funct3)
                        3'd0: op = OP_SUB;
                        3'd5: op = OP_SRA;
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            OPC_OP_IMM: begin
                case (funct3)
                    3'd0: op = OP_ADDI;
                    3'd2: op = OP_SLTI;
                    3'd3: op = OP_SLTIU;
                    3'd4: op = OP_XORI;
                    3'd6: op = OP_ORI;
                    3'd7: op = OP_ANDI;
                    3'd1: op = (funct7 == 7'h00) ? OP_SLLI : OP_ILLEGAL;
                    3'd5: begin
                        if (funct7 == 7'h00) begin
                            op = OP_SRLI;
                        end else if (funct7 == 7'h20) begin
                            op = OP_SRAI;
                        end
                    end
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD:  op = (funct3 == 3'd2) ? OP_LW : OP_ILLEGAL;
            OPC_STORE: op = (funct3 == 3'd2) ? OP_SW : OP_ILLEGAL;
            OPC_BRANCH: begin
                case (funct3)
                    3'd0: op = OP_BEQ;
                    3'd1: op = OP_BNE;
                    3'd4: op = OP_BLT;
                    3'd5: op = OP_BGE;
                    3'd6: op = OP_BLTU;
                    3'd7: op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_JAL:   op = OP_JAL;
            OPC_JALR:  op = (funct3 == 3'd0) ? OP_JALR : OP_ILLEGAL;
            OPC_LUI:   op = OP_LUI;
            OPC_AUIPC: op = OP_AUIPC;
            default:   op = OP_ILLEGAL;
        endcase
    end

    assign cuOP = op;

    // Immediate format follows the opcode alone; R-type and unknown opcodes yield 0.
    always_comb begin
        immOut = 32'd0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                immOut = {{20{instruction[31]}}, instruction[31:20]};
            OPC_STORE:
                immOut = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            OPC_BRANCH:
                immOut = {{19{instruction[31]}}, instruction[31], instruction[7],
                          instruction[30:25], instruction[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                immOut = {instruction[31:12], 12'd0};
            OPC_JAL:
                immOut = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                          instruction[20], instruction[30:21], 1'b0};
            default:
                immOut = 32'd0;
        endcase
    end

    logic is_alu_reg;
    logic is_branch;
    logic reg_we;

    assign is_alu_reg = (op >= OP_ADD) && (op <= OP_AND);
    assign is_branch  = (op >= OP_BEQ) && (op <= OP_BGEU);
    assign reg_we     = ((op >= OP_ADD) && (op <= OP_LW)) || (op >= OP_JAL);

    logic [31:0] regs [32];
    logic [31:0] rs1_dat;
    logic [31:0] rs2_dat;

    assign rs1_dat = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    assign rs2_dat = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

    assign aluIn  = ((op == OP_JAL) || (op == OP_AUIPC)) ? pc : rs1_dat;
    assign muxOut = (is_alu_reg || is_branch) ? rs2_dat : immOut;

    logic [4:0] shamt;
    assign shamt = muxOut[4:0];

    always_comb begin
        aluOut = aluIn + muxOut;
        case (op)
            OP_SUB, OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                aluOut = aluIn - muxOut;
            OP_SLL, OP_SLLI:
                aluOut = aluIn << shamt;
            OP_SLT, OP_SLTI:
                aluOut = {31'd0, $signed(aluIn) < $signed(muxOut)};
            OP_SLTU, OP_SLTIU:
                aluOut = {31'd0, aluIn < muxOut};
            OP_XOR, OP_XORI:
                aluOut = aluIn ^ muxOut;
            OP_SRL, OP_SRLI:
                aluOut = aluIn >> shamt;
            OP_SRA, OP_SRAI:
                aluOut = $unsigned($signed(aluIn) >>> shamt);
            OP_OR, OP_ORI:
                aluOut = aluIn | muxOut;
            OP_AND, OP_ANDI:
                aluOut = aluIn & muxOut;
            OP_LUI:
                aluOut = muxOut;
            default:
                aluOut = aluIn + muxOut;
        endcase
    end

    assign zero     = (aluOut == 32'd0);
    assign negative = aluOut[31];

    // Branch conditions compare the register operands directly, independent of the ALU result.
    logic br_eq;
    logic br_lt;
    logic br_ltu;
    logic br_taken;

    assign br_eq  = (rs1_dat == rs2_dat);
    assign br_lt  = ($signed(rs1_dat) < $signed(rs2_dat));
    assign br_ltu = (rs1_dat < rs2_dat);

    always_comb begin
        br_taken = 1'b0;
        case (op)
            OP_BEQ:  br_taken = br_eq;
            OP_BNE:  br_taken = !br_eq;
            OP_BLT:  br_taken = br_lt;
            OP_BGE:  br_taken = !br_lt;
            OP_BLTU: br_taken = br_ltu;
            OP_BGEU: br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    logic [31:0]        dmem [DMEM_WORDS];
    logic [DMEM_AW-1:0] dmem_addr;

    assign dmem_addr = aluOut[DMEM_AW+1:2];
    assign memload   = dmem[dmem_addr];

    logic [31:0] pc_plus4;
    logic [31:0] pc_next;

    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        writeData = aluOut;
        case (op)
            OP_LW:           writeData = memload;
            OP_JAL, OP_JALR: writeData = pc_plus4;
            OP_LUI:          writeData = immOut;
            default:         writeData = aluOut;
        endcase
    end

    always_comb begin
        pc_next = pc_plus4;
        if (br_taken || (op == OP_JAL)) begin
            pc_next = pc + immOut;
        end else if (op == OP_JALR) begin
            pc_next = aluOut & ~32'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pc <= RESET_PC;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc <= pc_next;
            if (reg_we && (rd != 5'd0)) begin
                regs[rd] <= writeData;
            end
        end
    end

    // Memory contents survive reset; reset only blocks the store on that edge.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
        end else if (op == OP_SW) begin
            dmem[dmem_addr] <= rs2_dat;
        end
    end

endmodule

// File: tb/tb_rv32_single_cycle_top.sv
// Randomized instruction stream against an architectural model of RV32I state.
module tb_rv32_single_cycle_top;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [5:0]  cuOP;
    logic [31:0] aluIn;
    logic [31:0] muxOut;
    logic [31:0] immOut;
    logic [31:0] aluOut;
    logic        zero;
    logic        negative;
    logic [31:0] memload;
    logic [31:0] writeData;

    always #5 clk = ~clk;

    rv32_single_cycle_top dut (
        .clk         (clk),
        .nrst        (nrst),
        .instruction (instruction),
        .pc          (pc),
        .cuOP        (cuOP),
        .aluIn       (aluIn),
        .muxOut      (muxOut),
        .immOut      (immOut),
        .aluOut      (aluOut),
        .zero        (zero),
        .negative    (negative),
        .memload     (memload),
        .writeData   (writeData)
    );

    int n_vec;
    int n_err;

    logic [31:0] m_reg  [32];
    logic [31:0] m_mem  [256];
    bit          m_mvld [256];
    logic [31:0] m_pc;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // Assemble an instruction from the op number used by cuOP and its operand fields.
    function automatic logic [31:0] enc(input int op, input int rd, input int rs1, input int rs2,
                                        input logic [31:0] imm);
        logic [4:0]  d;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] r;
        d  = rd[4:0];
        s1 = rs1[4:0];
        s2 = rs2[4:0];
        f3 = 3'd0;
        f7 = 7'd0;
        r  = 32'd0;
        case (op)
            1:  f3 = 3'd0;
            2:  begin f3 = 3'd0; f7 = 7'h20; end
            3:  f3 = 3'd1;
            4:  f3 = 3'd2;
            5:  f3 = 3'd3;
            6:  f3 = 3'd4;
            7:  f3 = 3'd5;
            8:  begin f3 = 3'd5; f7 = 7'h20; end
            9:  f3 = 3'd6;
            10: f3 = 3'd7;
            11: f3 = 3'd0;
            12: f3 = 3'd2;
            13: f3 = 3'd3;
            14: f3 = 3'd4;
            15: f3 = 3'd6;
            16: f3 = 3'd7;
            17: f3 = 3'd1;
            18: f3 = 3'd5;
            19: f3 = 3'd5;
            22: f3 = 3'd0;
            23: f3 = 3'd1;
            24: f3 = 3'd4;
            25: f3 = 3'd5;
            26: f3 = 3'd6;
            27: f3 = 3'd7;
            default: f3 = 3'd0;
        endcase
        if (op >= 1 && op <= 10)       r = {f7, s2, s1, f3, d, 7'b0110011};
        else if (op >= 11 && op <= 19) r = {imm[11:0], s1, f3, d, 7'b0010011};
        else if (op == 20)             r = {imm[11:0], s1, 3'd2, d, 7'b0000011};
        else if (op == 21)             r = {imm[11:5], s2, s1, 3'd2, imm[4:0], 7'b0100011};
        else if (op >= 22 && op <= 27) r = {imm[12], imm[10:5], s2, s1, f3, imm[4:1], imm[11], 7'b1100011};
        else if (op == 28)             r = {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
        else if (op == 29)             r = {imm[11:0], s1, 3'd0, d, 7'b1100111};
        else if (op == 30)             r = {imm[31:12], d, 7'b0110111};
        else if (op == 31)             r = {imm[31:12], d, 7'b0010111};
        return r;
    endfunction

    // Apply one instruction, compare against the model, then let the clock edge retire it.
    task automatic exec(input logic [31:0] ins, input int op, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm);
        logic [31:0] a, b, opb, res, wd, npc;
        logic [4:0]  sh;
        bit          we, taken, has_alu;
        int          idx;
        @(negedge clk);
        instruction = ins;
        #1;
        a   = m_reg[rs1];
        b   = m_reg[rs2];
        opb = ((op >= 1 && op <= 10) || (op >= 22 && op <= 27)) ? b : imm;
        sh  = opb[4:0];
        res = 32'd0;
        taken = 1'b0;
        npc = m_pc + 32'd4;
        case (op)
            1, 11, 20, 21: res = a + opb;
            2:      res = a - opb;
            3, 17:  res = a << sh;
            4, 12:  res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            5, 13:  res = (a < opb) ? 32'd1 : 32'd0;
            6, 14:  res = a ^ opb;
            7, 18:  res = a >> sh;
            8, 19:  res = $unsigned($signed(a) >>> sh);
            9, 15:  res = a | opb;
            10, 16: res = a & opb;
            22:     taken = (a == b);
            23:     taken = (a != b);
            24:     taken = ($signed(a) < $signed(b));
            25:     taken = ($signed(a) >= $signed(b));
            26:     taken = (a < b);
            27:     taken = (a >= b);
            28:     begin res = m_pc + imm; npc = res; end
            29:     begin res = a + imm; npc = res & 32'hFFFF_FFFE; end
            31:     res = m_pc + imm;
            default: ;
        endcase
        if (taken) npc = m_pc + imm;
        idx     = int'((res >> 2) % 32'd256);
        has_alu = (op >= 1 && op <= 21) || op == 28 || op == 29 || op == 31;
        we      = (op >= 1 && op <= 20) || op >= 28;
        if (op == 20)                wd = m_mem[idx];
        else if (op == 28 || op == 29) wd = m_pc + 32'd4;
        else if (op == 30)           wd = imm;
        else                         wd = res;

        chk_val("pc", pc, m_pc);
        chk_val("cuOP", {26'd0, cuOP}, 32'(op));
        if (op != 0) begin
            chk_val("immOut", immOut, (op <= 10) ? 32'd0 : imm);
            chk_val("muxOut", muxOut, opb);
            if (op != 30) chk_val("aluIn", aluIn, (op == 28 || op == 31) ? m_pc : a);
        end
        if (has_alu) begin
            chk_val("aluOut", aluOut, res);
            chk_val("zero", {31'd0, zero}, (res == 32'd0) ? 32'd1 : 32'd0);
            chk_val("negative", {31'd0, negative}, (res >= 32'h8000_0000) ? 32'd1 : 32'd0);
        end
        if ((op == 20 || op == 21) && m_mvld[idx]) chk_val("memload", memload, m_mem[idx]);
        if (we) chk_val("writeData", writeData, wd);

        if (we && rd != 0) m_reg[rd] = wd;
        if (op == 21) begin
            m_mem[idx]  = b;
            m_mvld[idx] = 1'b1;
        end
        m_pc = npc;
        @(posedge clk);
    endtask

    task automatic rand_instr();
        int          op, rd, rs1, rs2;
        logic [31:0] r, imm, ins;
        op  = $urandom_range(0, 31);
        rd  = $urandom_range(0, 15);
        rs1 = $urandom_range(0, 15);
        rs2 = $urandom_range(0, 15);
        r   = $urandom;
        imm = 32'd0;
        if ((op >= 11 && op <= 16) || op == 20 || op == 21 || op == 29)
            imm = {{20{r[11]}}, r[11:0]};
        else if (op == 17 || op == 18) imm = {27'd0, r[4:0]};
        else if (op == 19)             imm = 32'h400 | {27'd0, r[4:0]};
        else if (op >= 22 && op <= 27) imm = {{19{r[12]}}, r[12:1], 1'b0};
        else if (op == 28)             imm = {{11{r[20]}}, r[20:1], 1'b0};
        else if (op >= 30)             imm = {r[31:12], 12'd0};
        if (op == 0) ins = {r[31:7], (r[0] ? 7'b0001111 : 7'b1110011)};
        else         ins = enc(op, rd, rs1, rs2, imm);
        exec(ins, op, rd, rs1, rs2, imm);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        nrst = 1'b0;
        instruction = 32'd0;
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        for (int i = 0; i < 256; i++) begin
            m_mem[i]  = 32'd0;
            m_mvld[i] = 1'b0;
        end
        m_pc = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_pc", pc, 32'd0);
        nrst = 1'b1;

        exec(32'h3e800093, 11, 1, 0, 0, 32'd1000);
        exec(32'h83000113, 11, 2, 0, 0, 32'hFFFF_F830);
        exec(32'h3e906193, 15, 3, 0, 0, 32'd1001);
        exec(32'h45707213, 16, 4, 0, 0, 32'h457);
        exec(32'h3f31f213, 16, 4, 3, 0, 32'd1011);
        exec(32'h00102023, 21, 0, 0, 1, 32'd0);
        exec(32'h00002283, 20, 5, 0, 0, 32'd0);
        exec(32'h00500013, 11, 0, 0, 0, 32'd5);
        exec(enc(1, 6, 0, 0, 32'd0), 1, 6, 0, 0, 32'd0);
        exec(enc(1, 7, 1, 5, 32'd0), 1, 7, 1, 5, 32'd0);
        exec(enc(9, 8, 4, 2, 32'd0), 9, 8, 4, 2, 32'd0);
        exec(32'h00000463, 22, 0, 0, 0, 32'd8);
        exec(32'h00001463, 23, 0, 0, 0, 32'd8);

        for (int k = 0; k < 256; k++) exec(enc(21, 0, 0, 0, 32'(k * 4)), 21, 0, 0, 0, 32'(k * 4));

        repeat (1500) rand_instr();

        // Reset between edges: pending write of x5 must be lost, state clears at once.
        @(negedge clk);
        instruction = enc(11, 5, 0, 0, 32'd77);
        #1;
        nrst = 1'b0;
        #1;
        chk_val("midreset_pc", pc, 32'd0);
        for (int k = 1; k < 32; k++) begin
            instruction = enc(11, 0, k, 0, 32'd0);
            #1;
            chk_val("midreset_reg", aluIn, 32'd0);
        end
        for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
        m_pc = 32'd0;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        exec(enc(1, 6, 5, 0, 32'd0), 1, 6, 5, 0, 32'd0);

        repeat (200) rand_instr();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
